seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the fx2 multiplexed 7-segment driver.
- Samples the active-low digit-select and segment buses and reconstructs the 8-position display as hex codes, frame by frame.
- Flags frame completion and frame-to-frame change, which makes a right-to-left scroll visible as a sequence of frame_changed pulses.
- Sits beside the display driver for on-board self-check, or on a second board wired to the display pins.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before a digit strobe is accepted (range 2..255).
- TIMEOUT_CYCLES, 65536: idle cycles with a non-empty partial frame before that frame is force-closed (range 16..2^20).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- select  in  8  digit select, active-low, bit i = position i
- display  in  8  segments, active-low; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- chars  out  32  published frame; chars[4i+3:4i] = hex code at position i
- pos_valid  out  8  position i was strobed in the published frame with a recognised glyph
- dp_out  out  8  decimal point state per position in the published frame
- frame_done  out  1  one-cycle pulse when a new frame is published
- frame_changed  out  1  one-cycle pulse, coincident with frame_done, when the published content differs from the previous published frame
- multi_sel_err  out  1  one-cycle pulse per stable dwell in which more than one select bit is low

Behaviour:
- Reset, asynchronous, rst_n=0: chars=0, pos_valid=0, dp_out=0, all pulses 0. Synchronisers, stability counter, seen mask, working frame, timeout counter and previous-frame copy all cleared.
- Reset asserted mid-frame discards the partial frame; nothing is published.
- Input path: select and display each pass through a 2-flop synchroniser. Only the synchronised 16-bit sample is used downstream.
- Stability: stab_cnt clears when the sample differs from the prior cycle's sample, and increments (saturating) when equal.
- Dwell acceptance: a dwell is accepted on the cycle stab_cnt reaches STABLE_CYCLES-1. Each dwell is accepted once only; a new dwell requires a sample change.
- Dwell classes:
  - select all ones: idle; nothing happens.
  - exactly one bit low: strobe for position p.
  - two or more bits low: multi_sel_err pulses for 1 cycle; the dwell is otherwise ignored.
- Glyph decode: match display[7:1] against the table below; dp = ~display[0].
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern, including all-off: code 0, recognised=0.
- Strobe handling, evaluated in the cycle after acceptance:
  - If p is already in the seen mask: the current working frame is published first, then a new frame starts containing only p.
  - Otherwise: write code, recognised and dp into working slot p and set seen[p].
- Publish (one cycle):
  - chars, pos_valid and dp_out are loaded from the working frame; unseen positions publish code 0, pos_valid 0, dp 0.
  - frame_done=1.
  - frame_changed=1 if {chars,pos_valid,dp_out} differs from the previous publish. The first publish after reset counts as changed if it differs from the reset values.
- Timeout:
  - The counter increments every cycle while the seen mask is non-empty, and clears on every accepted strobe.
  - At TIMEOUT_CYCLES-1 the working frame is published and the seen mask cleared.
  - An empty seen mask never publishes.
- Latency: input edge to accepted strobe = 2 sync cycles + STABLE_CYCLES; working-slot update 1 cycle later.
- Simultaneous events: a wrap publish and a timeout in the same cycle produce exactly one publish, and the wrapping strobe starts the new frame.
- Outputs hold their values between publishes.

Test Plan:
- Reset: assert rst_n=0 mid-dwell -> all outputs 0 immediately. After release, with select=FF held, no frame_done.
- Single frame: scan positions 0..3 with glyphs 1,7,0,E, each held 8 cycles, then repeat position 0 -> one frame_done; chars[15:0]=16'hE071; pos_valid=8'h0F; frame_changed=1.
- Scroll: publish frames "1,7,0,1" then the same shifted left by one position -> each frame_done accompanied by frame_changed=1. An identical repeated frame -> frame_done=1, frame_changed=0.
- Glitch rejection: select changes held 2 cycles (less than STABLE_CYCLES=4) -> no slot update, no error.
- Multi-select and unknown glyph:
  - select=8'hFC held 10 cycles -> exactly one multi_sel_err pulse.
  - display=8'hFE on position 2 -> published pos_valid[2]=0, chars[11:8]=0, dp_out[2]=1.
- Timeout: strobe position 5 only, then idle with TIMEOUT_CYCLES=16 -> frame_done exactly 16 cycles after the last accepted strobe, with pos_valid=8'h20.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side decoder for a multiplexed, active-low 7-segment display bus.
// It samples the digit-select and segment lines and rebuilds the 8-position display as hex codes.
// It publishes one frame each time the scan wraps to a position already seen, or when the scan
// has been idle for too long.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   select[7:0]    digit select, active-low, bit i = position i
//   display[7:0]   segments, active-low; [7:1] = a..g, [0] = dp
//   chars[31:0]    published frame, chars[4i+3:4i] = hex code at position i
//   pos_valid[7:0] position i strobed with a recognised glyph in the published frame
//   dp_out[7:0]    decimal point per position in the published frame
//   frame_done     one-cycle pulse per publish
//   frame_changed  one-cycle pulse with frame_done when published content changed
//   multi_sel_err  one-cycle pulse per stable dwell with more than one select low
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  select,
  input  logic [7:0]  display,
  output logic [31:0] chars,
  output logic [7:0]  pos_valid,
  output logic [7:0]  dp_out,
  output logic        frame_done,
  output logic        frame_changed,
  output logic        multi_sel_err
);

  localparam logic [7:0]  StabLast = 8'(STABLE_CYCLES - 1);
  // Fire one count early so the publish becomes visible as the counter reaches TIMEOUT_CYCLES-1.
  localparam logic [20:0] ToFire   = 21'(TIMEOUT_CYCLES - 2);

  // Input synchronisers and stability tracking
  logic [7:0]  sel_m_q, sel_s_q, disp_m_q, disp_s_q;
  logic [2:0]  fill_q;
  logic [15:0] samp_prev_q;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [15:0] sample;

  // Accepted strobe, handled one cycle after acceptance
  logic        strb_vld_q, strb_vld_d;
  logic [2:0]  strb_pos_q, strb_pos_d;
  logic [3:0]  strb_code_q, strb_code_d;
  logic        strb_rec_q, strb_rec_d;
  logic        strb_dp_q, strb_dp_d;
  logic        err_q, err_d;

  // Working frame
  logic [7:0]  seen_q, seen_d;
  logic [31:0] wf_code_q, wf_code_d;
  logic [7:0]  wf_rec_q, wf_rec_d;
  logic [7:0]  wf_dp_q, wf_dp_d;
  logic [20:0] to_cnt_q, to_cnt_d;

  // Published frame
  logic [31:0] chars_q, chars_d;
  logic [7:0]  pv_q, pv_d;
  logic [7:0]  dp_q, dp_d;
  logic        done_q, done_d;
  logic        chg_q, chg_d;

  logic        accept, one_hot, multi, publish, cnt_inc, timeout;
  logic [7:0]  sel_n;
  logic [4:0]  glyph;
  logic [31:0] pub_chars;
  logic [7:0]  pub_pv, pub_dp;

  // Returns {recognised, code}
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    sample = {sel_s_q, disp_s_q};

    // Counting is held off until the synchronisers carry real input, so their reset value
    // (all selects low) is never accepted as a dwell.
    stab_cnt_d = stab_cnt_q;
    if (!fill_q[2] || (sample != samp_prev_q)) begin
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q != 8'hFF) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end

    // The counter passes StabLast exactly once per dwell, so each dwell is accepted once.
    // samp_prev_q is the dwell value here even if the live sample has just moved on.
    accept  = fill_q[2] && (stab_cnt_q == StabLast);
    sel_n   = ~samp_prev_q[15:8];
    one_hot = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
    multi   = (sel_n != 8'd0) && !one_hot;
    glyph   = decode_glyph(samp_prev_q[7:1]);

    strb_pos_d = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_n[i]) strb_pos_d = 3'(i);
    end
    strb_vld_d  = accept && one_hot;
    strb_code_d = glyph[3:0];
    strb_rec_d  = glyph[4];
    strb_dp_d   = ~samp_prev_q[0];
    err_d       = accept && multi;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pub_chars[4*i +: 4] = seen_q[i] ? wf_code_q[4*i +: 4] : 4'd0;
      pub_pv[i]           = seen_q[i] & wf_rec_q[i];
      pub_dp[i]           = seen_q[i] & wf_dp_q[i];
    end

    cnt_inc = (seen_q != 8'd0) || strb_vld_q;
    timeout = cnt_inc && (to_cnt_q == ToFire);

    seen_d    = seen_q;
    wf_code_d = wf_code_q;
    wf_rec_d  = wf_rec_q;
    wf_dp_d   = wf_dp_q;
    publish   = 1'b0;

    to_cnt_d = to_cnt_q;
    if (cnt_inc) to_cnt_d = to_cnt_q + 21'd1;
    if (timeout || strb_vld_d) to_cnt_d = 21'd0;

    if (strb_vld_q) begin
      // A revisited position (or a coincident timeout) closes the frame once;
      // the strobe then opens the next frame.
      if (seen_q[strb_pos_q] || timeout) begin
        publish = 1'b1;
        seen_d  = 8'd0;
      end
      for (int i = 0; i < 8; i++) begin
        if (strb_pos_q == 3'(i)) begin
          seen_d[i]           = 1'b1;
          wf_code_d[4*i +: 4] = strb_code_q;
          wf_rec_d[i]         = strb_rec_q;
          wf_dp_d[i]          = strb_dp_q;
        end
      end
    end else if (timeout) begin
      publish = 1'b1;
      seen_d  = 8'd0;
    end

    chars_d = chars_q;
    pv_d    = pv_q;
    dp_d    = dp_q;
    done_d  = publish;
    chg_d   = publish && ({pub_chars, pub_pv, pub_dp} != {chars_q, pv_q, dp_q});
    if (publish) begin
      chars_d = pub_chars;
      pv_d    = pub_pv;
      dp_d    = pub_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m_q     <= 8'd0;
      sel_s_q     <= 8'd0;
      disp_m_q    <= 8'd0;
      disp_s_q    <= 8'd0;
      fill_q      <= 3'd0;
      samp_prev_q <= 16'd0;
      stab_cnt_q  <= 8'd0;
      strb_vld_q  <= 1'b0;
      strb_pos_q  <= 3'd0;
      strb_code_q <= 4'd0;
      strb_rec_q  <= 1'b0;
      strb_dp_q   <= 1'b0;
      err_q       <= 1'b0;
      seen_q      <= 8'd0;
      wf_code_q   <= 32'd0;
      wf_rec_q    <= 8'd0;
      wf_dp_q     <= 8'd0;
      to_cnt_q    <= 21'd0;
      chars_q     <= 32'd0;
      pv_q        <= 8'd0;
      dp_q        <= 8'd0;
      done_q      <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      sel_m_q     <= select;
      sel_s_q     <= sel_m_q;
      disp_m_q    <= display;
      disp_s_q    <= disp_m_q;
      fill_q      <= {fill_q[1:0], 1'b1};
      samp_prev_q <= sample;
      stab_cnt_q  <= stab_cnt_d;
      strb_vld_q  <= strb_vld_d;
      strb_pos_q  <= strb_pos_d;
      strb_code_q <= strb_code_d;
      strb_rec_q  <= strb_rec_d;
      strb_dp_q   <= strb_dp_d;
      err_q       <= err_d;
      seen_q      <= seen_d;
      wf_code_q   <= wf_code_d;
      wf_rec_q    <= wf_rec_d;
      wf_dp_q     <= wf_dp_d;
      to_cnt_q    <= to_cnt_d;
      chars_q     <= chars_d;
      pv_q        <= pv_d;
      dp_q        <= dp_d;
      done_q      <= done_d;
      chg_q       <= chg_d;
    end
  end

  assign chars         = chars_q;
  assign pos_valid     = pv_q;
  assign dp_out        = dp_q;
  assign frame_done    = done_q;
  assign frame_changed = chg_q;
  assign multi_sel_err = err_q;

endmodule
